vertex_homogenize: RTL and testbench

VERTEX_HOMOGENIZE -- requirements
Module: vertex_homogenize

---
 rtl/vertex_homogenize.sv | 228 ++++++++++++++++++++++
 tb/tb_vertex_homogenize.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vertex_homogenize.sv
// vertex_homogenize: builds a 4x4 clip-space matrix from four screen-space vertices,
// using one shared sequential shift-add multiplier for the eight X*W / Y*W products.
`default_nettype none

module vertex_homogenize (
   input  logic               CLK,
   input  logic               rst,
   input  logic               start,
   input  logic signed [20:0] vtx1_X,
   input  logic signed [20:0] vtx2_X,
   input  logic signed [20:0] vtx3_X,
   input  logic signed [20:0] vtx4_X,
   input  logic signed [20:0] vtx1_Y,
   input  logic signed [20:0] vtx2_Y,
   input  logic signed [20:0] vtx3_Y,
   input  logic signed [20:0] vtx4_Y,
   input  logic signed [20:0] vtx1_Z,
   input  logic signed [20:0] vtx2_Z,
   input  logic signed [20:0] vtx3_Z,
   input  logic signed [20:0] vtx4_Z,
   output logic signed [20:0] d11,
   output logic signed [20:0] d12,
   output logic signed [20:0] d13,
   output logic signed [20:0] d14,
   output logic signed [20:0] d21,
   output logic signed [20:0] d22,
   output logic signed [20:0] d23,
   output logic signed [20:0] d24,
   output logic signed [20:0] d31,
   output logic signed [20:0] d32,
   output logic signed [20:0] d33,
   output logic signed [20:0] d34,
   output logic signed [20:0] d41,
   output logic signed [20:0] d42,
   output logic signed [20:0] d43,
   output logic signed [20:0] d44,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MUL   = 3'd2,
      S_STORE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [4:0]         cnt_q, cnt_d;
   logic signed [20:0] x_q [4];
   logic signed [20:0] x_d [4];
   logic signed [20:0] y_q [4];
   logic signed [20:0] y_d [4];
   logic signed [20:0] w_q [4];
   logic signed [20:0] w_d [4];
   logic signed [20:0] d1_q [4];
   logic signed [20:0] d1_d [4];
   logic signed [20:0] d2_q [4];
   logic signed [20:0] d2_d [4];
   logic signed [20:0] d4_q [4];
   logic signed [20:0] d4_d [4];
   logic [41:0]        mcand_q, mcand_d;
   logic [21:0]        mplier_q, mplier_d;
   logic [41:0]        acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [1:0]         vsel;
   logic signed [20:0] opa;
   logic signed [20:0] opb;
   logic signed [20:0] store_val;

   // 22-bit magnitude so that -1048576 becomes +1048576 without wrapping
   function automatic logic [21:0] mag22(input logic signed [20:0] v);
      logic signed [21:0] e;
      e = {v[20], v};
      mag22 = v[20] ? $unsigned(-e) : $unsigned(e);
   endfunction

   assign vsel = idx_q[2:1];
   assign opa  = idx_q[0] ? y_q[vsel] : x_q[vsel];
   assign opb  = w_q[vsel];

   always_comb begin
      store_val = '0;
      if (!neg_q) begin
         store_val = (acc_q > 42'd1048575) ? 21'h0FFFFF : acc_q[20:0];
      end else begin
         store_val = (acc_q > 42'd1048576) ? 21'h100000 : 21'(~acc_q[20:0] + 21'd1);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      w_d      = w_q;
      d1_d     = d1_q;
      d2_d     = d2_q;
      d4_d     = d4_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = '{vtx1_X, vtx2_X, vtx3_X, vtx4_X};
               y_d     = '{vtx1_Y, vtx2_Y, vtx3_Y, vtx4_Y};
               w_d     = '{vtx1_Z, vtx2_Z, vtx3_Z, vtx4_Z};
               d4_d    = '{vtx1_Z, vtx2_Z, vtx3_Z, vtx4_Z};
               idx_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            mcand_d  = {20'd0, mag22(opa)};
            mplier_d = mag22(opb);
            acc_d    = '0;
            cnt_d    = 5'd0;
            neg_d    = opa[20] ^ opb[20];
            state_d  = S_MUL;
         end
         S_MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = 5'(cnt_q + 5'd1);
            if (cnt_q == 5'd20) begin
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            if (idx_q[0]) begin
               d2_d[vsel] = store_val;
            end else begin
               d1_d[vsel] = store_val;
            end
            if (idx_q == 3'd7) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d   = 3'(idx_q + 3'd1);
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            x_q[i]  <= '0;
            y_q[i]  <= '0;
            w_q[i]  <= '0;
            d1_q[i] <= '0;
            d2_q[i] <= '0;
            d4_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         x_q      <= x_d;
         y_q      <= y_d;
         w_q      <= w_d;
         d1_q     <= d1_d;
         d2_q     <= d2_d;
         d4_q     <= d4_d;
      end
   end

   assign d11  = d1_q[0];
   assign d12  = d1_q[1];
   assign d13  = d1_q[2];
   assign d14  = d1_q[3];
   assign d21  = d2_q[0];
   assign d22  = d2_q[1];
   assign d23  = d2_q[2];
   assign d24  = d2_q[3];
   assign d31  = '0;
   assign d32  = '0;
   assign d33  = '0;
   assign d34  = '0;
   assign d41  = d4_q[0];
   assign d42  = d4_q[1];
   assign d43  = d4_q[2];
   assign d44  = d4_q[3];
   assign busy = busy_q;
   assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vertex_homogenize.sv
// tb_vertex_homogenize: directed vectors with hand-computed products, checking
// per-product write timing, saturation, input isolation and reset abort.
`default_nettype none

module tb_vertex_homogenize;

   logic               CLK = 1'b0;
   logic               rst;
   logic               start;
   logic signed [20:0] vx [4];
   logic signed [20:0] vy [4];
   logic signed [20:0] vw [4];
   logic signed [20:0] d11, d12, d13, d14, d21, d22, d23, d24;
   logic signed [20:0] d31, d32, d33, d34, d41, d42, d43, d44;
   logic               busy, done;

   // expected products for the vectors in flight, and what the outputs currently hold
   logic signed [20:0] e1 [4];
   logic signed [20:0] e2 [4];
   logic signed [20:0] ew [4];
   logic signed [20:0] c1 [4];
   logic signed [20:0] c2 [4];
   logic signed [20:0] dm1 [4];
   logic signed [20:0] dm2 [4];
   logic signed [20:0] dm3 [4];
   logic signed [20:0] dm4 [4];

   int n_chk = 0;
   int n_err = 0;

   vertex_homogenize dut (
      .CLK(CLK), .rst(rst), .start(start),
      .vtx1_X(vx[0]), .vtx2_X(vx[1]), .vtx3_X(vx[2]), .vtx4_X(vx[3]),
      .vtx1_Y(vy[0]), .vtx2_Y(vy[1]), .vtx3_Y(vy[2]), .vtx4_Y(vy[3]),
      .vtx1_Z(vw[0]), .vtx2_Z(vw[1]), .vtx3_Z(vw[2]), .vtx4_Z(vw[3]),
      .d11(d11), .d12(d12), .d13(d13), .d14(d14),
      .d21(d21), .d22(d22), .d23(d23), .d24(d24),
      .d31(d31), .d32(d32), .d33(d33), .d34(d34),
      .d41(d41), .d42(d42), .d43(d43), .d44(d44),
      .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      dm1 = '{d11, d12, d13, d14};
      dm2 = '{d21, d22, d23, d24};
      dm3 = '{d31, d32, d33, d34};
      dm4 = '{d41, d42, d43, d44};
   end

   task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h (%0d) expected %h (%0d)", tag, obs, $signed(obs), exp, $signed(exp));
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_model();
      for (int k = 0; k < 4; k++) begin
         c1[k] = '0;
         c2[k] = '0;
      end
   endtask

   // One full operation; perturb scrambles inputs and re-pulses start mid-run.
   task automatic do_run(input bit perturb);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_capture", 21'(busy), 21'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("d4%0d_capture", k + 1), dm4[k], ew[k]);
         chk($sformatf("d3%0d_zero", k + 1), dm3[k], 21'd0);
      end
      for (int e = 1; e <= 184; e++) begin
         tick();
         if (perturb && e == 50) begin
            for (int k = 0; k < 4; k++) begin
               vx[k] = 21'sd77 + 21'(k);
               vy[k] = -21'sd99;
               vw[k] = 21'sd3;
            end
            start = 1'b1;
         end
         if (perturb && e == 52) start = 1'b0;
         if (e % 23 == 22) begin
            int p;
            p = e / 23;
            if (p[0]) chk($sformatf("d2%0d_hold_e%0d", p / 2 + 1, e), dm2[p / 2], c2[p / 2]);
            else      chk($sformatf("d1%0d_hold_e%0d", p / 2 + 1, e), dm1[p / 2], c1[p / 2]);
         end
         if (e % 23 == 0) begin
            int p;
            p = e / 23 - 1;
            if (p[0]) begin
               chk($sformatf("d2%0d_store_e%0d", p / 2 + 1, e), dm2[p / 2], e2[p / 2]);
               c2[p / 2] = e2[p / 2];
            end else begin
               chk($sformatf("d1%0d_store_e%0d", p / 2 + 1, e), dm1[p / 2], e1[p / 2]);
               c1[p / 2] = e1[p / 2];
            end
         end
         if (e < 184) begin
            if (busy !== 1'b1 || done !== 1'b0) chk($sformatf("busy_done_e%0d", e), {19'd0, busy, done}, 21'b10);
         end
      end
      chk("done_at_184", 21'(done), 21'd1);
      chk("busy_at_184", 21'(busy), 21'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_one_cycle", 21'(done), 21'd0);
      tick();
      chk("no_queued_start", 21'(busy), 21'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("final_d1%0d", k + 1), dm1[k], e1[k]);
         chk($sformatf("final_d2%0d", k + 1), dm2[k], e2[k]);
         chk($sformatf("final_d4%0d", k + 1), dm4[k], ew[k]);
      end
   endtask

   task automatic load_set_a();
      vx = '{21'sd3, -21'sd7, 21'sd0, 21'sd2000};
      vy = '{-21'sd5, 21'sd7, 21'sd5, -21'sd2000};
      vw = '{21'sd4, -21'sd6, -21'sd9, 21'sd1000};
      ew = vw;
      e1 = '{21'sd12, 21'sd42, 21'sd0, 21'h0FFFFF};
      e2 = '{-21'sd20, -21'sd42, -21'sd45, 21'h100000};
   endtask

   task automatic load_set_b();
      vx = '{21'h100000, -21'sd2000, 21'sd1023, 21'sd1024};
      vy = '{21'sd1, 21'sd0, -21'sd1025, -21'sd1024};
      vw = '{21'sd1, 21'sd1000, 21'sd1025, -21'sd1024};
      ew = vw;
      e1 = '{21'h100000, 21'h100000, 21'h0FFFFF, 21'h100000};
      e2 = '{21'sd1, 21'sd0, 21'h100000, 21'h0FFFFF};
   endtask

   initial begin
      bit saw_done;
      rst   = 1'b1;
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vx[k] = '0;
         vy[k] = '0;
         vw[k] = '0;
      end
      clear_model();
      tick();
      tick();
      chk("rst_busy", 21'(busy), 21'd0);
      chk("rst_done", 21'(done), 21'd0);
      chk("rst_d11", d11, 21'd0);
      chk("rst_d24", d24, 21'd0);
      rst = 1'b0;
      tick();
      chk("idle_busy", 21'(busy), 21'd0);

      load_set_a();
      do_run(1'b0);

      load_set_b();
      do_run(1'b1);
      repeat (5) tick();
      chk("hold_idle_d11", d11, 21'h100000);
      chk("hold_idle_d23", d23, 21'h100000);

      // abort at cycle 100
      load_set_a();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (100) tick();
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 21'(busy), 21'd0);
      chk("abort_done", 21'(done), 21'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("abort_d1%0d", k + 1), dm1[k], 21'd0);
         chk($sformatf("abort_d2%0d", k + 1), dm2[k], 21'd0);
         chk($sformatf("abort_d4%0d", k + 1), dm4[k], 21'd0);
      end
      clear_model();
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("rst_wins_over_start", 21'(busy), 21'd0);
      saw_done = 1'b0;
      repeat (200) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      chk("no_done_after_abort", 21'(saw_done), 21'd0);

      load_set_a();
      do_run(1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
